// File: rtl/oam_dma_if.sv
// CPU-side and system-bus-side signals of the sprite DMA engine.
// slave = the DMA engine, master = the CPU core plus the system bus it drives.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rw;
  logic [7:0]  bus_din;
  logic        dma_active;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_rw, bus_din,
    output cpu_rdy, bus_addr, bus_dout, bus_rw, dma_active
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_rw, bus_din,
    input  cpu_rdy, bus_addr, bus_dout, bus_rw, dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to DMA_REG_ADDR, stalls the CPU and copies one
// 256-byte page to the OAM data port, one READ/WRITE pair per byte.
//
// state | meaning
// IDLE  | bus passes through the CPU, watching for a write to DMA_REG_ADDR
// HALT  | CPU stalled, bus still passes through (lets the trigger cycle settle)
// ALIGN | dummy read so that every READ falls on an even cycle
// READ  | read {page, idx} from the system bus into data_q
// WRITE | write data_q to OAM_DATA_ADDR, advance idx or finish after idx = FF
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        cyc_odd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      data_q    <= 8'h00;
      cyc_odd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      cyc_odd_q <= ~cyc_odd_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    page_d         = page_q;
    idx_d          = idx_q;
    data_d         = data_q;
    bus.cpu_rdy    = 1'b1;
    bus.dma_active = 1'b0;
    bus.bus_addr   = bus.cpu_addr;
    bus.bus_dout   = bus.cpu_dout;
    bus.bus_rw     = bus.cpu_rw;

    unique case (state_q)
      S_IDLE: begin
        // The trigger write itself still reaches the bus through the pass-through.
        if (!bus.cpu_rw && (bus.cpu_addr == DMA_REG_ADDR)) begin
          page_d  = bus.cpu_dout;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end

      S_HALT: begin
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        state_d        = cyc_odd_q ? S_READ : S_ALIGN;
      end

      S_ALIGN: begin
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        bus.bus_rw     = 1'b1;
        state_d        = S_READ;
      end

      S_READ: begin
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        bus.bus_addr   = {page_q, idx_q};
        bus.bus_dout   = data_q;
        bus.bus_rw     = 1'b1;
        data_d         = bus.bus_din;
        state_d        = S_WRITE;
      end

      S_WRITE: begin
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        bus.bus_addr   = OAM_DATA_ADDR;
        bus.bus_dout   = data_q;
        bus.bus_rw     = 1'b0;
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a RAM model answers bus reads and a monitor
// records every DMA-owned cycle; each scenario compares against a page-copy model.
module tb_oam_dma;
  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;
  int   cnt;

  oam_dma_if bif ();

  oam_dma #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bif.slave)
  );

  logic [7:0] mem [65536];
  assign bif.bus_din = mem[bif.bus_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle parity seen by the design: cycles since reset release, mod 2
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 0;
    else        cnt <= cnt + 1;

  logic [15:0] wr_a [$];
  logic [7:0]  wr_d [$];
  logic [15:0] rd_a [$];
  bit          rd_p [$];
  int          act_cnt, align_cnt, rdy_err;

  always @(negedge clk) begin
    if (rst_n && bif.dma_active === 1'b1) begin
      act_cnt++;
      if (bif.cpu_rdy !== 1'b0) rdy_err++;
      if (bif.bus_rw === 1'b0) begin
        wr_a.push_back(bif.bus_addr);
        wr_d.push_back(bif.bus_dout);
      end else if (bif.bus_addr !== bif.cpu_addr) begin
        rd_a.push_back(bif.bus_addr);
        rd_p.push_back(cnt[0]);
      end else if (act_cnt > 1) begin
        align_cnt++;
      end
    end
  end

  task automatic clear_mon();
    act_cnt = 0; align_cnt = 0; rdy_err = 0;
    wr_a.delete(); wr_d.delete(); rd_a.delete(); rd_p.delete();
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic check_copy(input logic [7:0] page, input bit halt_even, input string tag);
    logic [15:0] ea;
    vectors++;
    if (wr_a.size() != 256) begin errors++; $display("FAIL %s wr_count got %0d want 256", tag, wr_a.size()); end
    vectors++;
    if (rd_a.size() != 256) begin errors++; $display("FAIL %s rd_count got %0d want 256", tag, rd_a.size()); end
    for (int i = 0; i < 256; i++) begin
      ea = {page, 8'(i)};
      if (i < wr_a.size()) begin
        vectors++;
        if (wr_a[i] !== 16'h2004 || wr_d[i] !== mem[ea]) begin
          errors++;
          $display("FAIL %s write[%0d] got %h/%h want 2004/%h", tag, i, wr_a[i], wr_d[i], mem[ea]);
        end
      end
      if (i < rd_a.size()) begin
        vectors++;
        if (rd_a[i] !== ea || rd_p[i] !== 1'b0) begin
          errors++;
          $display("FAIL %s read[%0d] got %h odd=%0d want %h odd=0", tag, i, rd_a[i], rd_p[i], ea);
        end
      end
    end
    vectors++;
    if (act_cnt != 513 + int'(halt_even)) begin
      errors++; $display("FAIL %s stall got %0d want %0d", tag, act_cnt, 513 + int'(halt_even));
    end
    vectors++;
    if (align_cnt != int'(halt_even)) begin
      errors++; $display("FAIL %s align got %0d want %0d", tag, align_cnt, int'(halt_even));
    end
    vectors++;
    if (rdy_err != 0) begin errors++; $display("FAIL %s cpu_rdy_during_dma got %0d bad want 0", tag, rdy_err); end
  endtask

  // Trigger a copy of `page` with HALT on an even (want_even=1) or odd cycle.
  task automatic run_transfer(input logic [7:0] page, input bit want_even, input bit retrig,
                              input string tag);
    logic [15:0] idle;
    bit done;
    idle = {~page, 8'($urandom)};
    tick();
    while (cnt[0] != want_even) tick();
    clear_mon();
    bif.cpu_addr = 16'h4014; bif.cpu_rw = 1'b0; bif.cpu_dout = page;
    @(posedge clk); #1;
    bif.cpu_addr = idle; bif.cpu_rw = 1'b1; bif.cpu_dout = 8'($urandom);
    done = 1'b0;
    for (int t = 0; t < 700 && !done; t++) begin
      tick();
      if (retrig && act_cnt == 50) begin
        bif.cpu_addr = 16'h4014; bif.cpu_rw = 1'b0; bif.cpu_dout = 8'h07;
        @(posedge clk); #1;
        bif.cpu_addr = idle; bif.cpu_rw = 1'b1;
      end else if (act_cnt > 0 && bif.dma_active === 1'b0) begin
        done = 1'b1;
      end
    end
    vectors++;
    if (!done) begin errors++; $display("FAIL %s timeout act=%0d want completion", tag, act_cnt); end
    vectors++;
    if (bif.cpu_rdy !== 1'b1 || bif.bus_addr !== bif.cpu_addr) begin
      errors++;
      $display("FAIL %s end_idle rdy=%b addr=%h want rdy=1 addr=%h", tag, bif.cpu_rdy, bif.bus_addr, bif.cpu_addr);
    end
    check_copy(page, want_even, tag);
  endtask

  task automatic test_reset();
    logic rw;
    rst_n = 1'b0;
    rw = 1'($urandom);
    bif.cpu_addr = 16'h1234; bif.cpu_rw = rw; bif.cpu_dout = 8'($urandom);
    #23;
    vectors++;
    if (bif.cpu_rdy !== 1'b1 || bif.dma_active !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl rdy=%b act=%b want 1/0", bif.cpu_rdy, bif.dma_active);
    end
    vectors++;
    if (bif.bus_addr !== 16'h1234 || bif.bus_rw !== rw || bif.bus_dout !== bif.cpu_dout) begin
      errors++; $display("FAIL reset_pass addr=%h rw=%b want 1234/%b", bif.bus_addr, bif.bus_rw, rw);
    end
    @(negedge clk); rst_n = 1'b1;
    bif.cpu_rw = 1'b1;
  endtask

  task automatic test_read_no_trigger();
    tick();
    clear_mon();
    bif.cpu_addr = 16'h4014; bif.cpu_rw = 1'b1; bif.cpu_dout = 8'h02;
    @(posedge clk); #1;
    bif.cpu_addr = 16'h8123;
    repeat (6) tick();
    vectors++;
    if (act_cnt != 0) begin errors++; $display("FAIL read_trigger act=%0d want 0", act_cnt); end
  endtask

  task automatic test_basic_parity();
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    run_transfer(8'h02, 1'b1, 1'b0, "basic_even");
    run_transfer(8'h02, 1'b0, 1'b0, "basic_odd");
  endtask

  task automatic test_random_pages();
    logic [7:0] p;
    for (int n = 0; n < 3; n++) begin
      p = 8'($urandom_range(4, 254));
      run_transfer(p, 1'($urandom), 1'b0, "random");
    end
  endtask

  task automatic test_ignored_retrigger();
    run_transfer(8'h03, 1'($urandom), 1'b1, "retrig");
    clear_mon();
    repeat (20) tick();
    vectors++;
    if (act_cnt != 0) begin errors++; $display("FAIL retrig_restart act=%0d want 0", act_cnt); end
  endtask

  task automatic test_page_ff();
    int zero_hits;
    run_transfer(8'hFF, 1'($urandom), 1'b0, "page_ff");
    zero_hits = 0;
    foreach (rd_a[i]) if (rd_a[i] == 16'h0000) zero_hits++;
    vectors++;
    if (zero_hits != 0) begin errors++; $display("FAIL page_ff_wrap reads_at_0000=%0d want 0", zero_hits); end
  endtask

  task automatic test_reset_midop();
    logic [7:0] p;
    bit hit;
    p = 8'($urandom_range(4, 254));
    tick();
    clear_mon();
    bif.cpu_addr = 16'h4014; bif.cpu_rw = 1'b0; bif.cpu_dout = p;
    @(posedge clk); #1;
    bif.cpu_addr = {~p, 8'h00}; bif.cpu_rw = 1'b1;
    hit = 1'b0;
    for (int t = 0; t < 400 && !hit; t++) begin
      tick();
      if (wr_a.size() == 100) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin errors++; $display("FAIL midop_reach writes=%0d want 100", wr_a.size()); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bif.cpu_rdy !== 1'b1 || bif.dma_active !== 1'b0 || bif.bus_addr !== bif.cpu_addr) begin
      errors++;
      $display("FAIL midop_abort rdy=%b act=%b addr=%h want 1/0/%h", bif.cpu_rdy, bif.dma_active, bif.bus_addr, bif.cpu_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bif.cpu_addr = 16'h5A5A; bif.cpu_dout = 8'hC3; bif.cpu_rw = 1'b0;
    #1;
    vectors++;
    if (bif.bus_addr !== 16'h5A5A || bif.bus_dout !== 8'hC3 || bif.bus_rw !== 1'b0) begin
      errors++; $display("FAIL midop_pass addr=%h dout=%h rw=%b want 5A5A/C3/0", bif.bus_addr, bif.bus_dout, bif.bus_rw);
    end
    bif.cpu_rw = 1'b1;
    run_transfer(8'($urandom_range(4, 254)), 1'($urandom), 1'b0, "midop_fresh");
  endtask

  initial begin
    vectors = 0; errors = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    bif.cpu_addr = 16'h0000; bif.cpu_dout = 8'h00; bif.cpu_rw = 1'b1;
    clear_mon();
    test_reset();
    test_read_no_trigger();
    test_basic_parity();
    test_random_pages();
    test_ignored_retrigger();
    test_page_ff();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
